// File: rtl/decimal_key_scan_ctrl_pkg.sv
// Shared types and helpers for the decimal key scan controller.
package decimal_key_pkg;

  localparam int unsigned KEY_W  = 10;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    RELEASE
  } key_state_e;

  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [KEY_W-1:0] key);
    logic [CODE_W-1:0] code;
    code = CODE_NONE;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (key[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/decimal_key_scan_ctrl_if.sv
// Valid/ready event channel carrying one BCD key code.
interface decimal_key_scan_ctrl_if;
  import decimal_key_pkg::*;

  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ready_i;

  modport master (output code_o, output valid_o, input ready_i);
  modport slave  (input code_o, input valid_o, output ready_i);
endinterface

// File: rtl/decimal_key_scan_ctrl_encoder.sv
// Combinational 10:4 one-hot to BCD encoder with one-hot / multi-key flags.
module key_onehot_encoder
  import decimal_key_pkg::*;
(
  input  logic [KEY_W-1:0]  key,
  output logic [CODE_W-1:0] code,
  output logic              is_onehot,
  output logic              is_multi
);

  logic any_set;

  always_comb begin
    any_set   = (key != '0);
    is_onehot = any_set && ((key & (key - KEY_W'(1))) == '0);
    is_multi  = any_set && !is_onehot;
    code      = onehot_to_code(key);
  end

endmodule

// File: rtl/decimal_key_scan_ctrl.sv
// Debounced decimal key scanner producing one BCD event per press over valid/ready.
// Optional auto-repeat while a key is held: define KEY_AUTOREPEAT_EN.
module decimal_key_scan_ctrl
  import decimal_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_W-1:0]       key_i,
  decimal_key_scan_ctrl_if.master evt,
  output logic                   multi_err_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("decimal_key_scan_ctrl: DEBOUNCE_CYCLES must be >= 2, REPEAT_* >= 1");
  end

  logic [KEY_W-1:0]  key_m, key_s;
  key_state_e        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [KEY_W-1:0]  cand, cand_d;
  logic [CODE_W-1:0] cand_code, cand_code_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              multi_err_q, multi_err_d;
  logic              overflow_q, overflow_d;
  logic              issue;

  logic [CODE_W-1:0] enc_code;
  logic              enc_onehot, enc_multi;

  key_onehot_encoder u_enc (
    .key       (key_s),
    .code      (enc_code),
    .is_onehot (enc_onehot),
    .is_multi  (enc_multi)
  );

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;
  logic             rpt_seen, rpt_seen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt  <= '0;
      rpt_seen <= 1'b0;
    end else begin
      rpt_cnt  <= rpt_cnt_d;
      rpt_seen <= rpt_seen_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m       <= '0;
      key_s       <= '0;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      cand_code   <= CODE_NONE;
      code_q      <= CODE_NONE;
      valid_q     <= 1'b0;
      multi_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      key_m       <= key_i;
      key_s       <= key_m;
      state       <= state_d;
      cnt         <= cnt_d;
      cand        <= cand_d;
      cand_code   <= cand_code_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      multi_err_q <= multi_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cand_d      = cand;
    cand_code_d = cand_code;
    multi_err_d = 1'b0;
    issue       = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt;
    rpt_seen_d  = rpt_seen;
`endif

    unique case (state)
      IDLE: begin
        if (enc_multi) begin
          multi_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = RELEASE;
        end else if (enc_onehot) begin
          cand_d      = key_s;
          cand_code_d = enc_code;
          cnt_d       = '0;
          state_d     = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key_s != cand) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          issue   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (key_s == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
`ifdef KEY_AUTOREPEAT_EN
        // Counter pauses while extra keys are held and resumes on the original key alone.
        else if (key_s == cand) begin
          if (rpt_cnt == (rpt_seen ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
            issue      = 1'b1;
            rpt_cnt_d  = '0;
            rpt_seen_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt + RPT_W'(1);
          end
        end
`endif
      end
      RELEASE: begin
        if (key_s != '0) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KEY_AUTOREPEAT_EN
    if (state_d != HOLD) begin
      rpt_cnt_d  = '0;
      rpt_seen_d = 1'b0;
    end
`endif
  end

  // A transfer in the same cycle frees the holding register for the new event.
  always_comb begin
    valid_d    = valid_q;
    code_d     = code_q;
    overflow_d = 1'b0;
    if (valid_q && evt.ready_i) valid_d = 1'b0;
    if (issue) begin
      if (!valid_q || evt.ready_i) begin
        valid_d = 1'b1;
        code_d  = cand_code;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign evt.code_o  = code_q;
  assign evt.valid_o = valid_q;
  assign multi_err_o = multi_err_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_decimal_key_scan_ctrl.sv
// Directed bench for decimal_key_scan_ctrl: vector table plus multi-cycle corner sequences.
module tb_decimal_key_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_i;
  logic       multi_err_o, overflow_o, busy_o;

  decimal_key_scan_ctrl_if ifc ();

  decimal_key_scan_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (16),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (key_i),
    .evt         (ifc.master),
    .multi_err_o (multi_err_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned tx_cnt = 0, me_cnt = 0, ov_cnt = 0;
  logic [3:0]  last_code = 4'hF;

  // Inputs change 1 time unit after posedge, so the negedge sees the cycle's settled handshake.
  always @(negedge clk) begin
    if (ifc.valid_o && ifc.ready_i) begin
      tx_cnt++;
      last_code = ifc.code_o;
    end
    if (multi_err_o) me_cnt++;
    if (overflow_o)  ov_cnt++;
  end

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [9:0]  key;
    logic [3:0]  code;
    int unsigned n_ev;
    int unsigned n_me;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int unsigned t0, m0, o0;
    logic        early;

    vecs[0]  = '{10'b0000000001, 4'h0, 1, 0};
    vecs[1]  = '{10'b0000000010, 4'h1, 1, 0};
    vecs[2]  = '{10'b0000000100, 4'h2, 1, 0};
    vecs[3]  = '{10'b0000001000, 4'h3, 1, 0};
    vecs[4]  = '{10'b0000010000, 4'h4, 1, 0};
    vecs[5]  = '{10'b0000100000, 4'h5, 1, 0};
    vecs[6]  = '{10'b0001000000, 4'h6, 1, 0};
    vecs[7]  = '{10'b0010000000, 4'h7, 1, 0};
    vecs[8]  = '{10'b0100000000, 4'h8, 1, 0};
    vecs[9]  = '{10'b1000000000, 4'h9, 1, 0};
    vecs[10] = '{10'b0000100001, 4'h0, 0, 1};
    vecs[11] = '{10'b1100000000, 4'h0, 0, 1};
    vecs[12] = '{10'b1111111111, 4'h0, 0, 1};

    rst_n = 1'b0;
    key_i = '0;
    ifc.ready_i = 1'b0;
    cyc(3);
    chk("rst_valid", ifc.valid_o, 0);
    chk("rst_code", ifc.code_o, 0);
    chk("rst_multi", multi_err_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    cyc(2);

    // Table: every digit plus multi-key patterns, consumer always ready.
    ifc.ready_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      t0 = tx_cnt;
      m0 = me_cnt;
      key_i = vecs[i].key;
      cyc(14);
      key_i = '0;
      cyc(10);
      chk($sformatf("vec%0d_events", i), tx_cnt - t0, vecs[i].n_ev);
      chk($sformatf("vec%0d_multi", i), me_cnt - m0, vecs[i].n_me);
      if (vecs[i].n_ev != 0) chk($sformatf("vec%0d_code", i), last_code, vecs[i].code);
      chk($sformatf("vec%0d_idle", i), busy_o, 0);
    end

    // Latency: valid_o rises on edge 7 for exactly one cycle.
    t0 = tx_cnt;
    key_i = 10'b0010000000;
    early = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc(1);
      if (ifc.valid_o) early = 1'b1;
    end
    chk("lat_early", early, 0);
    cyc(1);
    chk("lat_valid_e7", ifc.valid_o, 1);
    chk("lat_code_e7", ifc.code_o, 4'h7);
    cyc(1);
    chk("lat_one_cycle", ifc.valid_o, 0);
    cyc(12);
    key_i = '0;
    cyc(10);
    chk("lat_single_event", tx_cnt - t0, 1);

    // Bounce: 2-cycle toggles must not produce an event.
    t0 = tx_cnt;
    for (int i = 0; i < 5; i++) begin
      key_i = (i % 2 == 1) ? 10'b0000001000 : 10'b0;
      cyc(2);
    end
    key_i = 10'b0000001000;
    early = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc(1);
      if (ifc.valid_o) early = 1'b1;
    end
    chk("bounce_no_early", early, 0);
    chk("bounce_no_event", tx_cnt - t0, 0);
    cyc(1);
    chk("bounce_valid", ifc.valid_o, 1);
    chk("bounce_code", ifc.code_o, 4'h3);
    cyc(14);
    key_i = '0;
    cyc(10);
    chk("bounce_events", tx_cnt - t0, 1);

    // Backpressure: 5 held, 9 dropped with one overflow pulse.
    ifc.ready_i = 1'b0;
    t0 = tx_cnt;
    o0 = ov_cnt;
    key_i = 10'b0000100000;
    cyc(12);
    chk("bp_valid5", ifc.valid_o, 1);
    chk("bp_code5", ifc.code_o, 4'h5);
    key_i = '0;
    cyc(10);
    key_i = 10'b1000000000;
    cyc(12);
    chk("bp_still_valid", ifc.valid_o, 1);
    chk("bp_code_stable", ifc.code_o, 4'h5);
    chk("bp_overflow", ov_cnt - o0, 1);
    key_i = '0;
    cyc(10);
    ifc.ready_i = 1'b1;
    cyc(1);
    ifc.ready_i = 1'b0;
    cyc(3);
    chk("bp_transfers", tx_cnt - t0, 1);
    chk("bp_xfer_code", last_code, 4'h5);
    chk("bp_drained", ifc.valid_o, 0);

    // Simultaneous: new 2 issues in the cycle the pending 8 transfers.
    key_i = 10'b0100000000;
    cyc(12);
    key_i = '0;
    cyc(10);
    chk("sim_pend_code", ifc.code_o, 4'h8);
    t0 = tx_cnt;
    o0 = ov_cnt;
    key_i = 10'b0000000100;
    cyc(6);
    ifc.ready_i = 1'b1;
    cyc(1);
    ifc.ready_i = 1'b0;
    chk("sim_valid", ifc.valid_o, 1);
    chk("sim_code", ifc.code_o, 4'h2);
    chk("sim_no_ovf", ov_cnt - o0, 0);
    chk("sim_xfer8", tx_cnt - t0, 1);
    chk("sim_xfer8_code", last_code, 4'h8);
    cyc(10);
    key_i = '0;
    cyc(10);
    ifc.ready_i = 1'b1;
    cyc(1);
    ifc.ready_i = 1'b0;
    cyc(1);
    chk("sim_xfer2", tx_cnt - t0, 2);
    chk("sim_xfer2_code", last_code, 4'h2);
    chk("sim_drained", ifc.valid_o, 0);

    // Asynchronous reset while in HOLD with a pending event.
    key_i = 10'b0001000000;
    cyc(10);
    chk("rh_pre_valid", ifc.valid_o, 1);
    chk("rh_pre_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rh_valid", ifc.valid_o, 0);
    chk("rh_code", ifc.code_o, 0);
    chk("rh_busy", busy_o, 0);
    chk("rh_multi", multi_err_o, 0);
    chk("rh_ovf", overflow_o, 0);
    key_i = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("rh_idle_valid", ifc.valid_o, 0);
    t0 = tx_cnt;
    ifc.ready_i = 1'b1;
    key_i = 10'b0000010000;
`ifdef KEY_AUTOREPEAT_EN
    cyc(40);
    key_i = '0;
    cyc(10);
    chk("rh_repeat_events", tx_cnt - t0, 4);
`else
    cyc(12);
    key_i = '0;
    cyc(10);
    chk("rh_events", tx_cnt - t0, 1);
`endif
    chk("rh_code4", last_code, 4'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
